// File: rtl/hdmi_qsys_irq_pkg.sv
// Shared constants for the QSYS interrupt controller: register map and widths.
package hdmi_qsys_irq_pkg;

    // Widest source count the 16-bit register format can carry.
    localparam int IRQ_MAX_SRC       = 16;

    // VECTOR register: flag bit marking an enabled pending source.
    localparam int IRQ_VEC_VALID_BIT = 15;

    // Register addresses on the 3-bit slave bus.
    localparam logic [2:0] IRQ_ADDR_PENDING  = 3'd0;
    localparam logic [2:0] IRQ_ADDR_MASK     = 3'd1;
    localparam logic [2:0] IRQ_ADDR_MODE     = 3'd2;
    localparam logic [2:0] IRQ_ADDR_SWSET    = 3'd3;
    localparam logic [2:0] IRQ_ADDR_VECTOR   = 3'd4;
    localparam logic [2:0] IRQ_ADDR_OVERFLOW = 3'd5;

endpackage

// File: rtl/hdmi_qsys_irq_prio_enc.sv
// Combinational priority encoder: the lowest-numbered asserted request wins.
module hdmi_qsys_irq_prio_enc #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [3:0]         idx
);

    // Scan from the top down so the last hit, the lowest index, is kept.
    always_comb begin
        // NOTE: outputs get defaults before the scan so no path leaves a latch.
        valid = |req;
        idx   = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/hdmi_qsys_irq_ctrl.sv
// Avalon-MM interrupt controller: per-source edge/level capture, software
// mask, overflow tracking, priority vector and one registered CPU irq.
module hdmi_qsys_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);

    import hdmi_qsys_irq_pkg::*;

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] overflow;

    logic [NUM_IRQ-1:0] wdata;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pend_set;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] ovf_set;
    logic [NUM_IRQ-1:0] ovf_clr;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] overflow_next;

    logic wr_any;
    logic wr_pending;
    logic wr_mask;
    logic wr_mode;
    logic wr_swset;
    logic wr_overflow;

    logic       vec_valid;
    logic [3:0] vec_idx;

    logic [IRQ_MAX_SRC-1:0] pending_ext;
    logic [IRQ_MAX_SRC-1:0] mask_ext;
    logic [IRQ_MAX_SRC-1:0] mode_ext;
    logic [IRQ_MAX_SRC-1:0] overflow_ext;
    logic [15:0]            rd_mux;

    // Write data bits above NUM_IRQ have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wdata       = writedata[NUM_IRQ-1:0];
    assign wr_any      = chipselect && !write_n;
    assign wr_pending  = wr_any && (address == IRQ_ADDR_PENDING);
    assign wr_mask     = wr_any && (address == IRQ_ADDR_MASK);
    assign wr_mode     = wr_any && (address == IRQ_ADDR_MODE);
    assign wr_swset    = wr_any && (address == IRQ_ADDR_SWSET);
    assign wr_overflow = wr_any && (address == IRQ_ADDR_OVERFLOW);

    assign rise = irq_q & ~irq_d;

    // Edge/level next-state for pending and overflow; set beats clear.
    always_comb begin
        pend_set      = rise | (wr_swset ? wdata : '0);
        pend_clr      = wr_pending ? wdata : '0;
        ovf_clr       = wr_overflow ? wdata : '0;
        // A rise only counts as lost if the earlier event is still unserviced.
        ovf_set       = mode & rise & pending & ~pend_clr;
        pending_next  = (mode & (pend_set | (pending & ~pend_clr))) | (~mode & irq_q);
        overflow_next = ovf_set | (overflow & ~ovf_clr);
    end

    // Input history, interrupt state and software-visible registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q    <= '0;
            irq_d    <= '0;
            pending  <= '0;
            mask     <= '0;
            mode     <= '0;
            overflow <= '0;
        end else begin
            // NOTE: non-blocking so each register samples pre-edge values of the others.
            irq_q    <= irq_in;
            irq_d    <= irq_q;
            pending  <= pending_next;
            overflow <= overflow_next;
            if (wr_mask) begin
                mask <= wdata;
            end
            if (wr_mode) begin
                mode <= wdata;
            end
        end
    end

    hdmi_qsys_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req   (pending & mask),
        .valid (vec_valid),
        .idx   (vec_idx)
    );

    // Zero-extend register images to the 16-bit bus and select by address.
    always_comb begin
        pending_ext                 = '0;
        mask_ext                    = '0;
        mode_ext                    = '0;
        overflow_ext                = '0;
        pending_ext[NUM_IRQ-1:0]    = pending;
        mask_ext[NUM_IRQ-1:0]       = mask;
        mode_ext[NUM_IRQ-1:0]       = mode;
        overflow_ext[NUM_IRQ-1:0]   = overflow;
        rd_mux                      = '0;
        case (address)
            IRQ_ADDR_PENDING:  rd_mux = pending_ext;
            IRQ_ADDR_MASK:     rd_mux = mask_ext;
            IRQ_ADDR_MODE:     rd_mux = mode_ext;
            IRQ_ADDR_VECTOR: begin
                rd_mux[IRQ_VEC_VALID_BIT] = vec_valid;
                rd_mux[3:0]               = vec_idx;
            end
            IRQ_ADDR_OVERFLOW: rd_mux = overflow_ext;
            default:           rd_mux = '0;
        endcase
    end

    // Registered read data and aggregated interrupt output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= |(pending & mask);
        end
    end

endmodule

// File: doc/hdmi_qsys_irq_ctrl.md
# hdmi_qsys_irq_ctrl

Avalon-MM interrupt controller downstream of the interval timer and other QSYS peripherals. It collects up to 16 same-clock interrupt request lines and latches edge events per source. It applies a software mask and drives one registered, aggregated `irq` to the CPU. It also exposes pending, overflow and priority-vector registers over the same 16-bit, 3-bit-address slave format the timer uses.

## Interface
- `NUM_IRQ`, default 8: number of sources; legal range 1..16. Register bits at or above `NUM_IRQ` read 0 and ignore writes.
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 3: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 16: write data.
- `readdata` out 16: registered read data. Reset value 0.
- `irq_in` in NUM_IRQ: source requests, synchronous to `clk`. Bit 0 is the highest priority.
- `irq` out 1: aggregated CPU interrupt, registered. Reset value 0.

## Operation
- Write strobe: `chipselect && !write_n && address==N`.
- Register map:
  - 0 PENDING: read returns pending bits. Write 1 clears edge-mode bits; level-mode bits ignore the write.
  - 1 MASK: read/write. 1 enables the source. Reset value 0.
  - 2 MODE: read/write. 1 selects edge mode, 0 selects level mode. Reset value 0 (level), which suits the timer irq because it holds until its status register is cleared.
  - 3 SWSET: write 1 sets pending for edge-mode bits. Reads return 0.
  - 4 VECTOR: read-only. bit15 = any enabled pending source; bits 3:0 = index of the lowest-numbered bit of `pending & mask`. Reads 0 when none is pending.
  - 5 OVERFLOW: read returns overflow bits; write 1 clears them. Reset value 0.
  - 6, 7: read 0; writes ignored.
- Input stage: `irq_q <= irq_in` and `irq_d <= irq_q` every cycle. Define `rise = irq_q & ~irq_d`.
- Edge-mode bit, next pending value:
  - 1 if `rise` or a SWSET 1 is written to that bit;
  - else 0 if a PENDING write 1 targets that bit;
  - else hold.
  - When set and clear occur in the same cycle, set wins.
- Level-mode bit: `pending <= irq_q` every cycle.
- Overflow bit: set on `rise` when pending is already 1 and is not being cleared in the same cycle. Set also wins over an OVERFLOW write-1 in the same cycle. Overflow bits are not tracked in level mode.
- Changing MODE from edge to level: the pending bit follows `irq_q` from the next cycle.
- `irq <= |(pending & mask)` every cycle.
- `readdata <=` the mux output for `address` every cycle, whether or not `chipselect` is asserted. A read therefore has 1-cycle latency.
- The VECTOR value is formed combinationally from the current pending and mask registers and captured into `readdata`.

## Timing
- Edge `irq_in` rise sampled at edge E: `irq_q=1` at E, pending=1 at E+1, `irq`=1 at E+2.
- Level mode has the same latency, and deassertion is symmetric.
- A PENDING or MASK write at edge W takes effect in the register at W, and `irq` reflects it at W+1.
- A read at edge R returns the register value as it stood before R. Read-after-write to the same register on consecutive cycles returns the new value.
- Reset mid-operation: every register goes to its reset value immediately. `irq` and `readdata` go to 0 asynchronously. The input history resets to 0, so an `irq_in` held high through reset deassertion produces one `rise`.

## Structure
- Shared package `hdmi_qsys_irq_pkg`:
  - address constants `IRQ_ADDR_PENDING` .. `IRQ_ADDR_OVERFLOW`;
  - `IRQ_MAX_SRC = 16`;
  - `IRQ_VEC_VALID_BIT = 15`.
- One sub-module, `hdmi_qsys_irq_prio_enc`: purely combinational, NUM_IRQ-wide to {valid, 4-bit index}, lowest index wins.
- Everything else is flat in the top module.

## Test plan
- **Reset default.** After reset: `readdata=0`, `irq=0`. Read MODE -> 0x0000. Read VECTOR -> 0x0000.
- **Level path.** Write MASK=0x0001, MODE=0. Hold `irq_in[0]` high from edge E -> `irq=1` at E+2. Drop `irq_in[0]` -> `irq=0` two cycles later. A PENDING write of 0x0001 while the input is still high has no effect.
- **Edge path and W1C.** Write MODE=0x00FF, MASK=0x0024. Pulse `irq_in[5]` for 1 cycle:
  - PENDING reads 0x0020; VECTOR reads 0x8005; `irq=1`.
  - Write PENDING 0x0020 -> `irq=0` the next cycle.
- **Priority and mask.** Pulse bits 2 and 5 together with MASK=0x0024 -> VECTOR reads 0x8002. Clear bit 2 -> VECTOR reads 0x8005. Set MASK=0 -> VECTOR reads 0x0000 and `irq=0`.
- **Simultaneous events.**
  - Edge on bit 1 in the same cycle as a PENDING write 0x0002 -> bit stays set.
  - A second edge while pending -> OVERFLOW reads 0x0002; write OVERFLOW 0x0002 -> reads 0x0000.
- **SWSET and unused bits.** With `NUM_IRQ=8`:
  - Write SWSET 0xFF01 in edge mode -> PENDING reads 0x0001.
  - Upper bits of every register read 0; addresses 6 and 7 read 0.
